// File: rtl/mpu_tile_loader_if.sv
// mpu_tile_loader_if -- bundles the byte-wide DRAM read port and the tile
// handshake towards the MPU.
//
// Handshake: mat_valid is raised by the loader once both tiles are complete
// and stays high, with a and b frozen, until an edge where mat_ready is also
// high; that edge transfers the tile pair. mat_ready is ignored while
// mat_valid is low. DRAM data for an address presented with dram_rd=1 appears
// on dram_dout exactly one cycle later.
interface mpu_tile_loader_if #(
   parameter int N      = 8,
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] dram_addr;
   logic              dram_rd;
   logic [7:0]        dram_dout;
   logic [N*N*8-1:0]  a;
   logic [N*N*8-1:0]  b;
   logic              mat_valid;
   logic              mat_ready;

   // Loader side
   modport master (
      output dram_addr, dram_rd, a, b, mat_valid,
      input  dram_dout, mat_ready
   );

   // DRAM / MPU side
   modport slave (
      input  dram_addr, dram_rd, a, b, mat_valid,
      output dram_dout, mat_ready
   );
endinterface

// File: rtl/mpu_tile_loader.sv
// mpu_tile_loader -- fetches an NxN int8 tile A and then tile B from a
// byte-wide DRAM (one read per cycle, row-major, strided rows), assembles
// them into packed registers and offers them to the MPU with valid/ready.
// Optional feature: define MPU_LOADER_TRANSPOSE_B_EN to store the B byte
// read from memory position (i,j) at element (j,i), turning a column-major B
// in DRAM into a row-major tile.
module mpu_tile_loader #(
   parameter int N      = 8,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
   input  logic [ADDR_W-1:0] stride,
   output logic              busy,
   output logic              done,
   output logic [2:0]        dbg_state_o,
   mpu_tile_loader_if.master bus
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int EW = (N > 1) ? $clog2(N * N) : 1;
   localparam int TW = N * N * 8;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_B  = 3'd2,
      DRAIN   = 3'd3,
      PRESENT = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     i_q, j_q;
   logic [ADDR_W-1:0] row_addr_q;
   logic [ADDR_W-1:0] b_base_q;
   logic [ADDR_W-1:0] stride_q;
   logic              cap_vld_q;
   logic              cap_b_q;
   logic [EW-1:0]     cap_idx_q;
   logic [EW-1:0]     cap_idx_d;
   logic [TW-1:0]     a_q, b_q;
   logic              done_q;
   logic              loading;
   logic              last_elem;
   logic [EW-1:0]     rm_idx;
   logic [EW-1:0]     tr_idx;

   assign loading   = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign last_elem = (i_q == LAST) && (j_q == LAST);
   assign rm_idx    = EW'(i_q) * EW'(N) + EW'(j_q);
   assign tr_idx    = EW'(j_q) * EW'(N) + EW'(i_q);

`ifdef MPU_LOADER_TRANSPOSE_B_EN
   assign cap_idx_d = (state_q == LOAD_B) ? tr_idx : rm_idx;
`else
   assign cap_idx_d = rm_idx;
   logic unused_tr;
   assign unused_tr = ^tr_idx;
`endif

   assign bus.a       = a_q;
   assign bus.b       = b_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      state_d       = state_q;
      bus.dram_rd   = 1'b0;
      bus.dram_addr = '0;
      bus.mat_valid = 1'b0;
      busy          = 1'b1;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = LOAD_A;
         end
         LOAD_A: begin
            bus.dram_rd   = 1'b1;
            bus.dram_addr = row_addr_q + ADDR_W'(j_q);
            if (last_elem) state_d = LOAD_B;
         end
         LOAD_B: begin
            bus.dram_rd   = 1'b1;
            bus.dram_addr = row_addr_q + ADDR_W'(j_q);
            if (last_elem) state_d = DRAIN;
         end
         DRAIN: state_d = PRESENT;
         PRESENT: begin
            bus.mat_valid = 1'b1;
            if (bus.mat_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read address generation: row base advances by stride, column by one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q        <= '0;
         j_q        <= '0;
         row_addr_q <= '0;
         b_base_q   <= '0;
         stride_q   <= '0;
      end else if (state_q == IDLE && start) begin
         i_q        <= '0;
         j_q        <= '0;
         row_addr_q <= a_base;
         b_base_q   <= b_base;
         stride_q   <= stride;
      end else if (loading) begin
         if (j_q == LAST) begin
            j_q <= '0;
            if (i_q == LAST) begin
               // End of a tile: the next read is B(0,0), with no gap
               i_q        <= '0;
               row_addr_q <= b_base_q;
            end else begin
               i_q        <= i_q + 1'b1;
               row_addr_q <= row_addr_q + stride_q;
            end
         end else begin
            j_q <= j_q + 1'b1;
         end
      end
   end

   // Remember which element each issued read belongs to, for one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_vld_q <= 1'b0;
         cap_b_q   <= 1'b0;
         cap_idx_q <= '0;
      end else begin
         cap_vld_q <= loading;
         cap_b_q   <= (state_q == LOAD_B);
         cap_idx_q <= cap_idx_d;
      end
   end

   // Write returning DRAM bytes into the tile registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else if (cap_vld_q) begin
         if (cap_b_q) b_q[int'(cap_idx_q) * 8 +: 8] <= bus.dram_dout;
         else         a_q[int'(cap_idx_q) * 8 +: 8] <= bus.dram_dout;
      end
   end

   // One-cycle completion pulse after the MPU takes the tile pair
   always_ff @(posedge clk or posedge rst) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= (state_q == PRESENT) && bus.mat_ready;
   end

endmodule

// File: tb/tb_mpu_tile_loader.sv
// tb_mpu_tile_loader -- self-checking bench for mpu_tile_loader (N=8,
// ADDR_W=16). Honors MPU_LOADER_TRANSPOSE_B_EN for the B-tile expectations.
module tb_mpu_tile_loader;

  localparam int N  = 8;
  localparam int AW = 16;
  localparam int TW = N * N * 8;
`ifdef MPU_LOADER_TRANSPOSE_B_EN
  localparam bit XPOSE = 1'b1;
`else
  localparam bit XPOSE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start;
  logic [AW-1:0] a_base, b_base, stride;
  logic          busy, done;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  mpu_tile_loader_if #(.N(N), .ADDR_W(AW)) bus ();

  mpu_tile_loader #(.N(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_base     (a_base),
    .b_base     (b_base),
    .stride     (stride),
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state),
    .bus        (bus)
  );

  // Byte-wide DRAM with one cycle of read latency
  logic [7:0] mem [0:65535];
  always @(posedge clk) bus.dram_dout <= mem[bus.dram_addr];

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic [TW-1:0] exp_a, exp_b;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Bus monitor: log read addresses, address must be 0 when no read, count done
  always @(negedge clk) begin
    if (bus.dram_rd === 1'b1) addr_log.push_back(bus.dram_addr);
    else if (rst === 1'b0) begin
      checks++;
      if (bus.dram_addr !== '0) begin
        failures++;
        $display("FAIL addr_idle: got %0h expected 0", bus.dram_addr);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic logic [TW-1:0] model_tile(input logic [AW-1:0] base, input logic [AW-1:0] st,
                                               input bit is_b);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        logic [AW-1:0] ad;
        int pos;
        ad  = base + AW'(i) * st + AW'(j);
        pos = (is_b && XPOSE) ? (j * N + i) : (i * N + j);
        t[pos*8 +: 8] = mem[ad];
      end
    return t;
  endfunction

  function automatic logic [7:0] el(input logic [TW-1:0] t, input int i, input int j);
    return t[(i*N+j)*8 +: 8];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_and_check(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                                input logic [AW-1:0] st, input bit repulse);
    int cnt;
    int errs;
    exp_a = model_tile(ab, st, 1'b0);
    exp_b = model_tile(bb, st, 1'b1);
    exp_q.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_q.push_back(ab + AW'(i) * st + AW'(j));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_q.push_back(bb + AW'(i) * st + AW'(j));
    @(negedge clk);
    addr_log.delete();
    a_base = ab; b_base = bb; stride = st; start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      start  = repulse && (cnt == 80);
      a_base = AW'($urandom);
      b_base = AW'($urandom);
      stride = AW'($urandom);
      if (cnt == 10) begin
        chk("busy_in_load", TW'(busy), TW'(1));
        chk("valid_in_load", TW'(bus.mat_valid), TW'(0));
      end
    end while (bus.mat_valid !== 1'b1 && cnt < 400);
    start = 1'b0;
    chk("latency", TW'(cnt), TW'(130));
    chk("tile_a", bus.a, exp_a);
    chk("tile_b", bus.b, exp_b);
    errs = 0;
    for (int k = 0; k < exp_q.size() && k < addr_log.size(); k++)
      if (addr_log[k] !== exp_q[k]) errs++;
    chk("addr_count", TW'(addr_log.size()), TW'(2 * N * N));
    chk("addr_seq_errs", TW'(errs), TW'(0));
  endtask

  task automatic accept(input int hold, input bit repulse);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      start = repulse && (k == 1);
      chk("hold_valid", TW'(bus.mat_valid), TW'(1));
      chk("hold_a", bus.a, exp_a);
      chk("hold_b", bus.b, exp_b);
    end
    start = 1'b0;
    bus.mat_ready = 1'b1;
    @(negedge clk);
    bus.mat_ready = 1'b0;
    chk("done_pulse", TW'(done), TW'(1));
    chk("busy_after_accept", TW'(busy), TW'(0));
    chk("valid_after_accept", TW'(bus.mat_valid), TW'(0));
    @(negedge clk);
    chk("done_single", TW'(done), TW'(0));
    repeat (3) @(negedge clk);
    chk("done_count", TW'(done_cnt - d0), TW'(1));
    chk("no_restart", TW'(busy), TW'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] a_base, b_base, stride;
    logic [7:0]    a00, a77, b01, b10;
    logic [AW-1:0] addr7, addr8;
    int            hold;
  } vec_t;

  vec_t tv[4];
  logic [AW-1:0] wrap_row[8];
  logic [63:0]   row_ref;
  int            d0;

  initial begin
    start = 1'b0; a_base = '0; b_base = '0; stride = '0;
    bus.mat_ready = 1'b0;
    for (int x = 0; x < 65536; x++) mem[x] = 8'(x);

    tv[0] = '{16'h0000, 16'h0100, 16'h0008, 8'h00, 8'h3F,
              XPOSE ? 8'h08 : 8'h01, XPOSE ? 8'h01 : 8'h08, 16'h0007, 16'h0008, 20};
    tv[1] = '{16'hFFFC, 16'h0200, 16'h0010, 8'hFC, 8'h73,
              XPOSE ? 8'h10 : 8'h01, XPOSE ? 8'h01 : 8'h10, 16'h0003, 16'h000C, 3};
    tv[2] = '{16'h0010, 16'h0300, 16'h0000, 8'h10, 8'h17,
              XPOSE ? 8'h00 : 8'h01, XPOSE ? 8'h01 : 8'h00, 16'h0017, 16'h0010, 2};
    tv[3] = '{16'h1234, 16'hABCD, 16'h0003, 8'h34, 8'h50,
              XPOSE ? 8'hD0 : 8'hCE, XPOSE ? 8'hCE : 8'hD0, 16'h123B, 16'h1237, 0};
    wrap_row = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    chk("rst_busy", TW'(busy), TW'(0));
    chk("rst_done", TW'(done), TW'(0));
    chk("rst_valid", TW'(bus.mat_valid), TW'(0));
    chk("rst_rd", TW'(bus.dram_rd), TW'(0));
    chk("rst_addr", TW'(bus.dram_addr), TW'(0));
    chk("rst_a", bus.a, '0);
    chk("rst_b", bus.b, '0);
    rst = 1'b0;

    // Table-driven loads against hand-computed element values
    for (int t = 0; t < 4; t++) begin
      load_and_check(tv[t].a_base, tv[t].b_base, tv[t].stride, 1'b0);
      chk($sformatf("t%0d_a00", t), TW'(el(bus.a, 0, 0)), TW'(tv[t].a00));
      chk($sformatf("t%0d_a77", t), TW'(el(bus.a, 7, 7)), TW'(tv[t].a77));
      chk($sformatf("t%0d_b01", t), TW'(el(bus.b, 0, 1)), TW'(tv[t].b01));
      chk($sformatf("t%0d_b10", t), TW'(el(bus.b, 1, 0)), TW'(tv[t].b10));
      chk($sformatf("t%0d_addr7", t), TW'(addr_log.size() > 8 ? addr_log[7] : 16'hxxxx), TW'(tv[t].addr7));
      chk($sformatf("t%0d_addr8", t), TW'(addr_log.size() > 8 ? addr_log[8] : 16'hxxxx), TW'(tv[t].addr8));
      accept(tv[t].hold, 1'b0);
    end

    // Tiles hold in IDLE; mat_ready outside PRESENT has no effect
    d0 = done_cnt;
    bus.mat_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.mat_ready = 1'b0;
    chk("idle_hold_a", bus.a, exp_a);
    chk("idle_hold_b", bus.b, exp_b);
    chk("idle_ready_no_done", TW'(done_cnt - d0), TW'(0));
    chk("idle_ready_busy", TW'(busy), TW'(0));

    // Wrapping row addresses, start re-pulsed in LOAD_B and PRESENT
    load_and_check(16'hFFFC, 16'h0200, 16'h0010, 1'b1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("wrap_addr%0d", k), TW'(addr_log.size() > k ? addr_log[k] : 16'hxxxx), TW'(wrap_row[k]));
    accept(4, 1'b1);

    // stride=0: every row of a equals DRAM[0x10..0x17]
    load_and_check(16'h0010, 16'h0400, 16'h0000, 1'b0);
    for (int j = 0; j < N; j++) row_ref[j*8 +: 8] = mem[16'h0010 + AW'(j)];
    for (int i = 0; i < N; i++)
      chk($sformatf("stride0_row%0d", i), TW'(bus.a[i*64 +: 64]), TW'(row_ref));
    accept(1, 1'b0);

    // Reset 50 cycles into a load: immediate clear, no done, clean restart
    @(negedge clk);
    a_base = 16'h0000; b_base = 16'h0100; stride = 16'h0008; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", TW'(busy), TW'(0));
    chk("abort_done", TW'(done), TW'(0));
    chk("abort_valid", TW'(bus.mat_valid), TW'(0));
    chk("abort_rd", TW'(bus.dram_rd), TW'(0));
    chk("abort_addr", TW'(bus.dram_addr), TW'(0));
    chk("abort_a", bus.a, '0);
    chk("abort_b", bus.b, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", TW'(done_cnt - d0), TW'(0));
    chk("abort_idle", TW'(busy), TW'(0));
    load_and_check(16'h0000, 16'h0100, 16'h0008, 1'b0);
    accept(2, 1'b0);

    // Randomized memory contents, bases and strides against the model
    for (int x = 0; x < 65536; x++) mem[x] = 8'($urandom);
    for (int r = 0; r < 6; r++) begin
      load_and_check(AW'($urandom), AW'($urandom), AW'($urandom_range(0, 65535)), 1'b0);
      accept($urandom_range(0, 4), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
